// File: rtl/fft_pkg.sv
// fft_pkg
// Shared definitions for the FFT datapath blocks.
//   - CPLX_W / HALF_W : packed complex word width and half-word width
//   - cplx_pack / cplx_re / cplx_im : complex packing, real in the high half
//   - W_ONE, W_NEG_J, W_NEG_ONE, W_POS_J : Q15 twiddle constants
//   - bitrev : reverses the low 'width' bits of a value
//   - loader_state_t : states of the input loader
package fft_pkg;

   localparam int CPLX_W = 32;
   localparam int HALF_W = 16;

   localparam logic [CPLX_W-1:0] W_ONE     = 32'h7FFF0000;
   localparam logic [CPLX_W-1:0] W_NEG_J   = 32'h00008000;
   localparam logic [CPLX_W-1:0] W_NEG_ONE = 32'h80000000;
   localparam logic [CPLX_W-1:0] W_POS_J   = 32'h00007FFF;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2
   } loader_state_t;

   // Builds a packed complex word with the real part in the upper half.
   function automatic logic [CPLX_W-1:0] cplx_pack(input logic [HALF_W-1:0] re,
                                                   input logic [HALF_W-1:0] im);
      return {re, im};
   endfunction

   function automatic logic [HALF_W-1:0] cplx_re(input logic [CPLX_W-1:0] c);
      return c[CPLX_W-1:HALF_W];
   endfunction

   function automatic logic [HALF_W-1:0] cplx_im(input logic [CPLX_W-1:0] c);
      return c[HALF_W-1:0];
   endfunction

   // Reverses bits [width-1:0] of value; higher bits of the result are zero.
   function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < width) begin
            r[width-1-i] = value[i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_input_loader.sv
// fft_input_loader
// Collects N real samples into a frame buffer in bit-reversed order, then
// streams the N/2 first-stage butterfly operand pairs with the W^0 twiddle.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   s_valid, s_data   : sample stream in (signed SAMPLE_W bits)
//   s_ready           : high while the loader is filling (and not in reset)
//   m_valid, m_ready  : pair stream handshake out
//   m_a, m_b, m_w     : operand a, operand b, twiddle, packed {re, im} Q15
//   m_last            : marks the final pair of a frame
module fft_input_loader
   import fft_pkg::*;
#(
   parameter int N        = 64,
   parameter int SAMPLE_W = 16,
   parameter int SHIFT    = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_valid,
   input  logic [SAMPLE_W-1:0] s_data,
   output logic                s_ready,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [CPLX_W-1:0]   m_a,
   output logic [CPLX_W-1:0]   m_b,
   output logic [CPLX_W-1:0]   m_w,
   output logic                m_last
);

   localparam int IDX_W = $clog2(N);
   localparam int K_W   = IDX_W - 1;
   localparam logic [IDX_W-1:0] WI_MAX = IDX_W'(N - 1);
   localparam logic [K_W-1:0]   K_MAX  = K_W'(N / 2 - 1);

   loader_state_t state, state_next;

   logic [CPLX_W-1:0]         frame_buf [N];
   logic [IDX_W-1:0]          wi;
   logic [K_W-1:0]            k;
   logic [K_W-1:0]            k_inc;
   logic [IDX_W-1:0]          wr_addr;
   logic signed [SAMPLE_W-1:0] shifted;
   logic                      s_fire;
   logic                      m_fire;

   assign s_ready = (state == ST_FILL) && !rst;
   assign s_fire  = s_valid && s_ready;
   assign m_fire  = m_valid && m_ready;
   assign k_inc   = k + 1'b1;
   assign wr_addr = IDX_W'(bitrev(32'(wi), IDX_W));
   assign shifted = $signed(s_data) >>> SHIFT;

   // Only first-stage pairs are produced, so the twiddle is always W^0.
   assign m_w = W_ONE;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_FILL;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: fill until N samples, one load cycle, drain until the
   // pair marked last is accepted.
   always_comb begin
      state_next = state;
      case (state)
         ST_FILL: begin
            if (s_fire && (wi == WI_MAX)) begin
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (m_fire && m_last) begin
               state_next = ST_FILL;
            end
         end
         default: begin
            state_next = ST_FILL;
         end
      endcase
   end

   // Frame buffer: samples land at their bit-reversed slot so that pairs
   // (2k, 2k+1) read out directly as first-stage butterfly inputs. Contents
   // are deliberately left alone by reset.
   always_ff @(posedge clk) begin
      if (s_fire) begin
         frame_buf[wr_addr] <= cplx_pack(HALF_W'(shifted), '0);
      end
   end

   // Counters and output registers. The next pair is loaded at the same edge
   // that retires the current one, so the drain runs without bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         wi      <= '0;
         k       <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
         m_a     <= '0;
         m_b     <= '0;
      end else begin
         case (state)
            ST_FILL: begin
               if (s_fire) begin
                  wi <= (wi == WI_MAX) ? '0 : wi + 1'b1;
               end
            end
            ST_LOAD: begin
               k       <= '0;
               m_a     <= frame_buf[0];
               m_b     <= frame_buf[1];
               m_valid <= 1'b1;
               m_last  <= (K_MAX == '0);
            end
            ST_DRAIN: begin
               if (m_fire) begin
                  if (m_last) begin
                     m_valid <= 1'b0;
                     m_last  <= 1'b0;
                     k       <= '0;
                  end else begin
                     k      <= k_inc;
                     m_a    <= frame_buf[{k_inc, 1'b0}];
                     m_b    <= frame_buf[{k_inc, 1'b1}];
                     m_last <= (k_inc == K_MAX);
                  end
               end
            end
            default: begin
               m_valid <= 1'b0;
               m_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader
// Directed bench for fft_input_loader with N=8. A second instance with
// SHIFT=1 exercises the arithmetic pre-shift.
// For an N=8 frame x0..x7 the pairs come out as
// (x0,x4), (x2,x6), (x1,x5), (x3,x7).
module tb_fft_input_loader;

   logic        clk;
   logic        rst;
   logic        s_valid, s_valid_s;
   logic [15:0] s_data, s_data_s;
   logic        s_ready, s_ready_s;
   logic        m_valid, m_valid_s;
   logic        m_ready, m_ready_s;
   logic [31:0] m_a, m_b, m_w, m_a_s, m_b_s, m_w_s;
   logic        m_last, m_last_s;

   int total;
   int bad;

   int a_idx [4] = '{0, 2, 1, 3};
   int b_idx [4] = '{4, 6, 5, 7};
   logic [31:0] exp_a, exp_b;

   fft_input_loader #(.N(8), .SAMPLE_W(16), .SHIFT(0)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_ready(m_ready),
      .m_a(m_a), .m_b(m_b), .m_w(m_w), .m_last(m_last)
   );

   fft_input_loader #(.N(8), .SAMPLE_W(16), .SHIFT(1)) dut_s (
      .clk(clk), .rst(rst),
      .s_valid(s_valid_s), .s_data(s_data_s), .s_ready(s_ready_s),
      .m_valid(m_valid_s), .m_ready(m_ready_s),
      .m_a(m_a_s), .m_b(m_b_s), .m_w(m_w_s), .m_last(m_last_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_sample(input logic [15:0] d);
      s_valid = 1'b1;
      s_data  = d;
      step();
      s_valid = 1'b0;
   endtask

   task automatic send_frame(input int base);
      for (int i = 0; i < 8; i++) begin
         send_sample(16'(base + i));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      s_valid_s = 1'b0; s_data_s = '0; m_ready_s = 1'b0;
      step();
      step();
      total++;
      if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_ctrl: got rdy=%b v=%b last=%b, want 0 0 0", s_ready, m_valid, m_last);
      end
      total++;
      if (m_a !== 32'h0 || m_b !== 32'h0 || m_w !== 32'h7FFF0000) begin
         bad++;
         $display("[TB] FAIL reset_data: got a=%h b=%h w=%h, want 0 0 7fff0000", m_a, m_b, m_w);
      end
      rst = 1'b0;
      #1;
      total++;
      if (s_ready !== 1'b1 || s_ready_s !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_release: got rdy=%b rdy_s=%b, want 1 1", s_ready, s_ready_s);
      end
   endtask

   task automatic test_basic();
      send_frame(1);
      total++;
      if (m_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL basic_load_cycle: got v=%b, want 0", m_valid);
      end
      m_ready = 1'b1;
      step();
      total++;
      if (m_valid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL basic_latency: got v=%b, want 1", m_valid);
      end
      for (int p = 0; p < 4; p++) begin
         exp_a = {16'(1 + a_idx[p]), 16'h0000};
         exp_b = {16'(1 + b_idx[p]), 16'h0000};
         total++;
         if (m_valid !== 1'b1 || m_a !== exp_a || m_b !== exp_b || m_w !== 32'h7FFF0000) begin
            bad++;
            $display("[TB] FAIL basic_pair%0d: got v=%b a=%h b=%h w=%h, want 1 %h %h 7fff0000",
                     p, m_valid, m_a, m_b, m_w, exp_a, exp_b);
         end
         total++;
         if (m_last !== 1'(p == 3) || s_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_last%0d: got last=%b rdy=%b, want %b 0", p, m_last, s_ready, 1'(p == 3));
         end
         step();
      end
      total++;
      if (m_valid !== 1'b0 || m_last !== 1'b0 || s_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL basic_end: got v=%b last=%b rdy=%b, want 0 0 1", m_valid, m_last, s_ready);
      end
      m_ready = 1'b0;
   endtask

   task automatic test_shift();
      for (int i = 0; i < 8; i++) begin
         s_valid_s = 1'b1;
         s_data_s  = (i == 0) ? 16'h8000 : ((i == 4) ? 16'h0003 : 16'h0000);
         step();
      end
      s_valid_s = 1'b0;
      step();
      total++;
      if (m_valid_s !== 1'b1 || m_a_s !== 32'hC0000000 || m_b_s !== 32'h00010000) begin
         bad++;
         $display("[TB] FAIL shift_pair0: got v=%b a=%h b=%h, want 1 c0000000 00010000", m_valid_s, m_a_s, m_b_s);
      end
      m_ready_s = 1'b1;
      step();
      total++;
      if (m_a_s !== 32'h0 || m_b_s !== 32'h0 || m_w_s !== 32'h7FFF0000) begin
         bad++;
         $display("[TB] FAIL shift_pair1: got a=%h b=%h w=%h, want 0 0 7fff0000", m_a_s, m_b_s, m_w_s);
      end
      repeat (3) step();
      m_ready_s = 1'b0;
      total++;
      if (m_valid_s !== 1'b0 || s_ready_s !== 1'b1) begin
         bad++;
         $display("[TB] FAIL shift_end: got v=%b rdy=%b, want 0 1", m_valid_s, s_ready_s);
      end
   endtask

   task automatic test_backpressure();
      send_frame(16'h11);
      step();
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      exp_a = {16'(16'h11 + 2), 16'h0000};
      exp_b = {16'(16'h11 + 6), 16'h0000};
      for (int c = 0; c < 3; c++) begin
         s_valid = 1'b1;
         s_data  = 16'h7777;
         #1;
         total++;
         if (m_valid !== 1'b1 || m_a !== exp_a || m_b !== exp_b || s_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_hold%0d: got v=%b a=%h b=%h rdy=%b, want 1 %h %h 0",
                     c, m_valid, m_a, m_b, s_ready, exp_a, exp_b);
         end
         step();
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      step();
      exp_a = {16'(16'h11 + 1), 16'h0000};
      exp_b = {16'(16'h11 + 5), 16'h0000};
      total++;
      if (m_valid !== 1'b1 || m_a !== exp_a || m_b !== exp_b) begin
         bad++;
         $display("[TB] FAIL bp_pair2: got v=%b a=%h b=%h, want 1 %h %h", m_valid, m_a, m_b, exp_a, exp_b);
      end
      step();
      total++;
      if (m_last !== 1'b1 || m_a !== {16'h0014, 16'h0000} || m_b !== {16'h0018, 16'h0000}) begin
         bad++;
         $display("[TB] FAIL bp_pair3: got last=%b a=%h b=%h, want 1 00140000 00180000", m_last, m_a, m_b);
      end
      step();
      m_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      send_frame(1);
      m_ready = 1'b1;
      repeat (5) step();
      total++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_ready: got rdy=%b v=%b, want 1 0", s_ready, m_valid);
      end
      send_frame(9);
      step();
      for (int p = 0; p < 4; p++) begin
         exp_a = {16'(9 + a_idx[p]), 16'h0000};
         exp_b = {16'(9 + b_idx[p]), 16'h0000};
         total++;
         if (m_valid !== 1'b1 || m_a !== exp_a || m_b !== exp_b || m_last !== 1'(p == 3)) begin
            bad++;
            $display("[TB] FAIL b2b_pair%0d: got v=%b a=%h b=%h last=%b, want 1 %h %h %b",
                     p, m_valid, m_a, m_b, m_last, exp_a, exp_b, 1'(p == 3));
         end
         step();
      end
      m_ready = 1'b0;
   endtask

   task automatic test_reset_mid_drain();
      send_frame(16'h21);
      m_ready = 1'b1;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      total++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL drain_reset: got v=%b rdy=%b, want 0 1", m_valid, s_ready);
      end
      send_frame(16'h31);
      step();
      for (int p = 0; p < 4; p++) begin
         exp_a = {16'(16'h31 + a_idx[p]), 16'h0000};
         exp_b = {16'(16'h31 + b_idx[p]), 16'h0000};
         total++;
         if (m_valid !== 1'b1 || m_a !== exp_a || m_b !== exp_b || m_last !== 1'(p == 3)) begin
            bad++;
            $display("[TB] FAIL drain_pair%0d: got v=%b a=%h b=%h last=%b, want 1 %h %h %b",
                     p, m_valid, m_a, m_b, m_last, exp_a, exp_b, 1'(p == 3));
         end
         step();
      end
      total++;
      if (m_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL drain_no_stale: got v=%b, want 0", m_valid);
      end
      m_ready = 1'b0;
   endtask

   task automatic test_reset_mid_fill();
      for (int i = 0; i < 5; i++) begin
         send_sample(16'(16'h41 + i));
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         send_sample(16'(16'h51 + i));
      end
      for (int c = 0; c < 3; c++) begin
         total++;
         if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL fill_wait%0d: got v=%b rdy=%b, want 0 1", c, m_valid, s_ready);
         end
         step();
      end
      send_sample(16'h58);
      m_ready = 1'b1;
      step();
      for (int p = 0; p < 4; p++) begin
         exp_a = {16'(16'h51 + a_idx[p]), 16'h0000};
         exp_b = {16'(16'h51 + b_idx[p]), 16'h0000};
         total++;
         if (m_valid !== 1'b1 || m_a !== exp_a || m_b !== exp_b || m_last !== 1'(p == 3)) begin
            bad++;
            $display("[TB] FAIL fill_pair%0d: got v=%b a=%h b=%h last=%b, want 1 %h %h %b",
                     p, m_valid, m_a, m_b, m_last, exp_a, exp_b, 1'(p == 3));
         end
         step();
      end
      m_ready = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      s_valid_s = 1'b0; s_data_s = '0; m_ready_s = 1'b0;
      test_reset();
      test_basic();
      test_shift();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_drain();
      test_reset_mid_fill();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_input_loader.md
Name: fft_input_loader

Overview:
Upstream feeder for the radix-2 butterfly. Collects N real audio samples over a valid/ready stream and stores them in bit-reversed order. Then streams N/2 first-stage operand pairs (a, b) plus twiddle w to the butterfly as packed complex words. Single frame buffer: the block alternates between a fill phase and a drain phase.

Parameters:
N, 64, FFT length; power of two, 4..1024
SAMPLE_W, 16, input sample width; equals the complex half-word width
SHIFT, 0, arithmetic right shift applied to each sample before packing (headroom), 0..15

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_valid  in  1  input sample valid
s_data  in  SAMPLE_W  signed audio sample
s_ready  out  1  loader accepts a sample this cycle
m_valid  out  1  output pair valid
m_ready  in  1  butterfly side accepts the pair
m_a  out  32  operand a, {real[15:0], imag[15:0]}, Q15
m_b  out  32  operand b, same packing
m_w  out  32  twiddle, same packing
m_last  out  1  high with the final pair of a frame

Behaviour:
- One clock: clk. Reset is synchronous and active-high: rst.
- Complex packing is real in bits [31:16] and imag in [15:0], two's complement Q15. Each stored word is {s_data >>> SHIFT, 16'h0000}.
- The sample shift is arithmetic (sign-preserving). No rounding.
- The buffer is a register array of N words. The write index counter wi is log2(N) bits. The pair counter k is log2(N)-1 bits.
- States:
  - FILL: s_ready = 1 (and !rst). On s_valid && s_ready, write buf[bitrev(wi)] and increment wi. When the handshake has wi == N-1, go to LOAD and reset wi to 0.
  - LOAD (1 cycle): s_ready = 0. Register pair k=0 into m_a/m_b, set m_valid = 1 and m_last = (N == 2·1 ? 1 : 0), then go to DRAIN.
  - DRAIN: s_ready = 0. m_a = buf[2k], m_b = buf[2k+1], m_w = 32'h7FFF0000 (1+j0; the stage-0 twiddle is always W^0).
    - On m_valid && m_ready with k < N/2-1: load pair k+1 at the same edge, with no bubble, and m_last = (k+1 == N/2-1).
    - On the handshake with m_last: m_valid = 0, m_last = 0, k = 0, go to FILL.
- Outputs are held stable while m_valid && !m_ready. m_valid never drops without a handshake, except on reset.
- Latency: m_valid rises 2 clocks after the edge that accepts the N-th sample. Throughput is 1 pair/clock under continuous m_ready. s_ready reasserts the cycle after the final output handshake.
- s_valid while s_ready = 0 is ignored; no data is captured. Upstream must hold its sample.
- Reset values: state FILL, wi 0, k 0, m_valid 0, m_last 0, m_a/m_b 0, m_w 32'h7FFF0000. s_ready reads 0 while rst is high and 1 on the first cycle after.
- Buffer contents are not cleared by reset.
- Reset mid-fill discards partial samples. Reset mid-drain abandons the remaining pairs. Either way, the next frame starts at wi = 0.
- bitrev(i) reverses the log2(N) bits of i.

Decomposition:
- Shared package fft_pkg holds:
  - CPLX_W = 32 and HALF_W = 16
  - complex pack/unpack functions (real high, imag low)
  - twiddle constants W_ONE = 32'h7FFF0000, W_NEG_J = 32'h00008000, W_NEG_ONE = 32'h80000000, W_POS_J = 32'h00007FFF
  - the bitrev function parameterised by width
- No sub-module: FSM, counters and register array live in one module.

Test Plan:
- N=8, SHIFT=0, samples 1..8, m_ready=1:
  - pairs in order are (32'h00010000, 32'h00050000), (0003_0000, 0007_0000), (0002_0000, 0006_0000), (0004_0000, 0008_0000)
  - m_last only on the 4th pair
  - m_w = 32'h7FFF0000 on every pair
  - m_valid rises 2 clocks after the 8th accept
- N=8, SHIFT=1, sample 0 = 16'h8000, sample 4 = 16'h0003, others 0 -> first pair m_a = 32'hC0000000, m_b = 32'h00010000.
- Backpressure: m_ready held low 3 cycles on pair 1 -> m_a/m_b/m_valid stable for those cycles; pair 2 appears one clock after m_ready rises. s_valid pulses during DRAIN are not captured (s_ready = 0).
- Back-to-back frames: the second frame of samples 9..16 is streamed immediately after the final handshake -> s_ready = 1 the cycle after m_last handshake; second frame first pair = (0009_0000, 000D_0000).
- Reset mid-drain after 2 pairs -> next cycle m_valid = 0, s_ready = 1. A fresh frame of 8 samples produces 4 correct pairs with no stale pair emitted.
- Reset mid-fill after 5 samples -> 8 further samples are required before m_valid rises, and the pairs reflect only the post-reset samples.
